// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parameterised UART receiver. The asynchronous rx line is synchronised and
// then sampled once per bit at the bit centre, with timing taken from the
// synchronised falling edge that opens the frame. No oversampling or
// majority vote is done.
//
// Parameters
//   CLK_DIV     clk cycles per bit period (4..65535)
//   DATA_BITS   data bits per frame (5..9)
//   PARITY      0 none, 1 odd, 2 even
//   SYNC_STAGES rx synchroniser depth (2..4)
//
// Ports
//   clk         rising-edge system clock
//   rstn        asynchronous active-low reset
//   rx_pin_in   asynchronous serial line, idle high
//   h2l_sig     one-cycle pulse per synchronised high-to-low transition
//   rx_data     last received word, LSB = first data bit
//   rx_valid    one-cycle pulse; rx_data and error flags valid with it
//   parity_err  parity mismatch of the current word (0 when PARITY = 0)
//   frame_err   stop bit of the current word was sampled low
//   busy        high whenever the receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLK_DIV     = 5208,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx_pin_in,
    output logic                 h2l_sig,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PAR     = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } state_t;

    // Returns 1 when data plus received parity bit disagree with the mode.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d,
                                             input logic                 p);
        logic x;
        x = ^{d, p};
        case (PARITY)
            1:       parity_mismatch = ~x;
            2:       parity_mismatch = x;
            default: parity_mismatch = 1'b0;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   h2l_r;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [IDX_W-1:0]       bit_idx_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   par_pend_r;
    logic [DATA_BITS-1:0]   rx_data_r;
    logic                   rx_valid_r;
    logic                   parity_err_r;
    logic                   frame_err_r;
    logic                   busy_r;

    logic line_s;
    logic edge_s;
    logic cnt_zero_s;
    logic last_bit_s;
    logic ld_half_s;
    logic ld_full_s;
    logic shift_s;
    logic par_smp_s;
    logic stop_smp_s;

    assign line_s     = sync_r[SYNC_STAGES-1];
    // Falling edge seen on the synchronised line; built from flops only.
    assign edge_s     = hist_r & ~line_s;
    assign cnt_zero_s = (cnt_r == '0);
    assign last_bit_s = (bit_idx_r == IDX_LAST);

    assign h2l_sig    = h2l_r;
    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

    // Input synchroniser plus one-flop edge history; both reset to idle-high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            hist_r <= 1'b1;
            h2l_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx_pin_in};
            hist_r <= line_s;
            h2l_r  <= edge_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and datapath strobes; every sample is taken when the
    // bit counter reaches zero, so mid-bit line changes never move timing.
    always_comb begin
        state_nxt_s = state_r;
        ld_half_s   = 1'b0;
        ld_full_s   = 1'b0;
        shift_s     = 1'b0;
        par_smp_s   = 1'b0;
        stop_smp_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (edge_s) begin
                    ld_half_s   = 1'b1;
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (cnt_zero_s) begin
                    if (!line_s) begin
                        ld_full_s   = 1'b1;
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (cnt_zero_s) begin
                    shift_s   = 1'b1;
                    ld_full_s = 1'b1;
                    if (last_bit_s) begin
                        state_nxt_s = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PAR: begin
                if (cnt_zero_s) begin
                    par_smp_s   = 1'b1;
                    ld_full_s   = 1'b1;
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PAR;
                end
            end
            STOP: begin
                if (cnt_zero_s) begin
                    stop_smp_s  = 1'b1;
                    state_nxt_s = line_s ? IDLE : WAIT_HI;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            WAIT_HI: begin
                // A low stop bit leaves the line low; wait for it to recover
                // so the tail of a broken frame cannot look like a start bit.
                if (line_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_HI;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bit counter, shift register and registered result/status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r        <= '0;
            bit_idx_r    <= '0;
            shift_r      <= '0;
            par_pend_r   <= 1'b0;
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            if (ld_half_s) begin
                cnt_r <= CNT_HALF;
            end else if (ld_full_s) begin
                cnt_r <= CNT_FULL;
            end else if (!cnt_zero_s) begin
                cnt_r <= cnt_r - CNT_ONE;
            end

            // Index is cleared when a frame opens, ready for the first data bit.
            if (ld_half_s) begin
                bit_idx_r <= '0;
            end else if (shift_s) begin
                bit_idx_r <= bit_idx_r + IDX_ONE;
            end

            if (shift_s) begin
                shift_r <= {line_s, shift_r[DATA_BITS-1:1]};
            end

            if (par_smp_s) begin
                par_pend_r <= parity_mismatch(shift_r, line_s);
            end

            if (stop_smp_s) begin
                rx_data_r    <= shift_r;
                frame_err_r  <= ~line_s;
                parity_err_r <= (PARITY != 0) ? par_pend_r : 1'b0;
            end

            rx_valid_r <= stop_smp_s;
            busy_r     <= (state_nxt_s != IDLE);
        end
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 5208, clk cycles per bit period (legal range 4..65535).
REQ-002 SHALL provide parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-003 SHALL provide parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL provide parameter SYNC_STAGES, default 2, rx input synchronizer depth (legal range 2..4).
REQ-005 SHALL provide port clk  input  1  rising-edge system clock.
REQ-006 SHALL provide port rstn  input  1  asynchronous, active-low reset.
REQ-007 SHALL provide port rx_pin_in  input  1  asynchronous serial line, idle high.
REQ-008 SHALL provide port h2l_sig  output  1  one-cycle pulse on each synchronized high-to-low line transition.
REQ-009 SHALL provide port rx_data  output  DATA_BITS  last received word, LSB = first data bit.
REQ-010 SHALL provide port rx_valid  output  1  one-cycle pulse; rx_data and error flags valid in that cycle.
REQ-011 SHALL provide port parity_err  output  1  parity mismatch for current word; always 0 when PARITY=0.
REQ-012 SHALL provide port frame_err  output  1  stop bit sampled low for current word.
REQ-013 SHALL provide port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 SHALL pass rx_pin_in through SYNC_STAGES flops reset to 1, plus one edge-history flop reset to 1.
REQ-015 SHALL drive h2l_sig = (history flop AND NOT synchronized line), registered or combinational from flops only, in every state.
REQ-016 SHALL implement states IDLE, START, DATA, PAR, STOP, WAIT_HI.
REQ-017 IDLE: on h2l_sig, load bit counter with CLK_DIV/2 - 1 (integer divide), go START.
REQ-018 START: on counter = 0, sample line; low -> load CLK_DIV-1, clear bit index, go DATA; high -> false start, go IDLE, no rx_valid.
REQ-019 DATA: on each counter expiry, shift sampled line into shift register LSB-first, reload CLK_DIV-1; after DATA_BITS samples go PAR if PARITY!=0 else STOP.
REQ-020 PAR: on counter expiry, sample parity bit; error if XOR(data, parity bit) is 0 for odd or 1 for even; reload CLK_DIV-1, go STOP.
REQ-021 STOP: on counter expiry, sample stop bit; in same cycle update rx_data, parity_err, frame_err and pulse rx_valid.
REQ-022 STOP exit: stop bit high -> IDLE next cycle; stop bit low -> WAIT_HI.
REQ-023 WAIT_HI: remain until synchronized line is high, then IDLE; falling edges in WAIT_HI SHALL NOT start a frame.
REQ-024 Every sample SHALL therefore occur at bit centre, i.e. k*CLK_DIV + CLK_DIV/2 cycles after h2l_sig, for k = 0 (start) onward.
REQ-025 Counter width SHALL be $clog2(CLK_DIV) bits, down-counting; no wrap beyond reload value.
REQ-026 rx_data, parity_err, frame_err SHALL hold their values between rx_valid pulses.
REQ-027 rx_valid SHALL pulse even when an error flag is set; errors do not suppress data.
REQ-028 Line changes mid-bit SHALL not alter FSM timing; only centre samples are used (no majority vote).
REQ-029 Latency: rx_valid asserts (1 + DATA_BITS + P) * CLK_DIV + CLK_DIV/2 cycles after h2l_sig, P = 0 or 1 per PARITY.
REQ-030 Back-to-back frames: a start edge arriving one cycle after STOP->IDLE SHALL be accepted.

Reset
REQ-031 rstn low SHALL asynchronously force FSM IDLE, counters 0, synchronizer and history flops 1, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, busy 0, h2l_sig 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no rx_valid; after release, reception restarts only on a new falling edge.
REQ-033 Reset release while line is low SHALL NOT start a frame until a high-to-low transition is observed.

Verification (bench uses CLK_DIV=16, DATA_BITS=8)
REQ-034 PARITY=0, send 0xA5 8N1 -> single rx_valid at 152 cycles (+sync delay) after edge, rx_data=0xA5, both error flags 0.
REQ-035 PARITY=2, send 0x3C with parity bit 1 -> rx_valid, rx_data=0x3C, parity_err=1, frame_err=0.
REQ-036 Start low for 4 cycles then high -> h2l_sig pulse, no rx_valid, busy returns 0 after 8 cycles.
REQ-037 Send 0x00 with stop bit low, line held low 40 cycles -> rx_valid with frame_err=1, FSM in WAIT_HI until line high, no spurious frame.
REQ-038 Two frames 0x55, 0xAA with zero idle gap -> two rx_valid pulses, data 0x55 then 0xAA, no errors.
REQ-039 rstn pulsed low during DATA bit 3 -> no rx_valid, all outputs 0, next full frame 0x81 received correctly.
